lif_neuron_multi: RTL

Parametrised leaky integrate-and-fire neuron, the successor to the 2-bit single-synapse neuron. It has N binary synaptic inputs, each with its own signed weight. The membrane is saturating and signed, with a programmable leak shift, threshold and refractory period, and a reset mode of either subtract or zero. A step/ready handshake advances one timestep through a 2-stage pipeline. A write-only config port sets the weights and neuron constants; it sits behind the tile-top IO wrapper.

---
 rtl/lif_pkg.sv | 36 +++
 rtl/lif_neuron_multi_weighted_sum.sv | 23 ++
 rtl/lif_neuron_multi.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/lif_pkg.sv
// Shared constants, FSM state type and saturation helper for the LIF neuron.
package lif_pkg;

    // Config register offsets, relative to N_INPUTS (weights occupy 0..N_INPUTS-1).
    localparam int CFG_THRESH_OFS = 0;
    localparam int CFG_SHIFT_OFS  = 1;
    localparam int CFG_REFRAC_OFS = 2;
    localparam int CFG_MODE_OFS   = 3;

    // Reset defaults.
    localparam int W_RST      = 1;
    localparam int THRESH_RST = 5;
    localparam int SHIFT_RST  = 1;

    typedef enum logic [1:0] {
        IDLE,
        SUM,
        UPDATE
    } lif_state_e;

    // Clamp a signed value to the range of a signed 'bits'-wide number.
    function automatic logic signed [31:0] saturate(input logic signed [31:0] val,
                                                    input int                 bits);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (bits - 1)) - 32'sd1;
        lo = -(32'sd1 <<< (bits - 1));
        if (val > hi) begin
            return hi;
        end else if (val < lo) begin
            return lo;
        end
        return val;
    endfunction

endpackage

// File: rtl/lif_neuron_multi_weighted_sum.sv
// Combinational masked weighted sum of the binary synaptic inputs.
module lif_weighted_sum import lif_pkg::*; #(
    parameter int N_INPUTS = 8,
    parameter int W_BITS   = 4,
    parameter int SUM_BITS = 8
) (
    input  logic [N_INPUTS-1:0]             x,
    input  logic [N_INPUTS-1:0][W_BITS-1:0] weights,
    output logic signed [SUM_BITS-1:0]      sum
);

    // Accumulate each active input's sign-extended weight; SUM_BITS is wide enough
    // that no intermediate can overflow.
    always_comb begin
        sum = '0;
        for (int i = 0; i < N_INPUTS; i++) begin
            if (x[i]) begin
                sum = sum + SUM_BITS'(signed'(weights[i]));
            end
        end
    end

endmodule

// File: rtl/lif_neuron_multi.sv
// Multi-input leaky integrate-and-fire neuron with config port and 3-cycle step.
module lif_neuron_multi import lif_pkg::*; #(
    parameter  int N_INPUTS    = 8,
    parameter  int W_BITS      = 4,
    parameter  int U_BITS      = 8,
    parameter  int SHIFT_BITS  = 3,
    parameter  int REFRAC_BITS = 3,
    localparam int CFG_AW      = $clog2(N_INPUTS + 4),
    localparam int D_BITS      = (W_BITS > U_BITS) ? W_BITS : U_BITS
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_INPUTS-1:0]      x,
    input  logic                     step,
    output logic                     step_ready,
    input  logic                     cfg_we,
    output logic                     cfg_ready,
    input  logic [CFG_AW-1:0]        cfg_addr,
    input  logic [D_BITS-1:0]        cfg_wdata,
    output logic                     spike,
    output logic                     spike_valid,
    output logic signed [U_BITS-1:0] u_out,
    output logic                     refractory
);

    localparam int SUM_BITS = W_BITS + $clog2(N_INPUTS) + 1;

    lif_state_e state_q, state_d;

    logic [N_INPUTS-1:0][W_BITS-1:0] weight_q;
    logic signed [U_BITS-1:0]        thresh_q;
    logic [SHIFT_BITS-1:0]           shift_q;
    logic [REFRAC_BITS-1:0]          refrac_len_q;
    logic                            mode_q;

    logic [N_INPUTS-1:0]             x_q;
    logic signed [SUM_BITS-1:0]      sum_comb, sum_q;
    logic signed [U_BITS-1:0]        u_q;
    logic [REFRAC_BITS-1:0]          refrac_cnt_q;
    logic                            spike_q;
    logic                            spike_valid_q;

    logic signed [U_BITS-1:0]        leak_u, u_int, u_sub, u_d;
    logic [REFRAC_BITS-1:0]          refrac_d;
    logic                            spike_d;
    logic                            cfg_take;

    assign cfg_ready = step_ready;
    assign cfg_take  = cfg_we && cfg_ready;

    lif_weighted_sum #(
        .N_INPUTS (N_INPUTS),
        .W_BITS   (W_BITS),
        .SUM_BITS (SUM_BITS)
    ) u_wsum (
        .x       (x_q),
        .weights (weight_q),
        .sum     (sum_comb)
    );

    // Config register file; writes land only while the neuron is idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N_INPUTS; i++) begin
                weight_q[i] <= W_BITS'(W_RST);
            end
            thresh_q     <= U_BITS'(THRESH_RST);
            shift_q      <= SHIFT_BITS'(SHIFT_RST);
            refrac_len_q <= '0;
            mode_q       <= 1'b0;
        end else if (cfg_take) begin
            for (int i = 0; i < N_INPUTS; i++) begin
                if (cfg_addr == CFG_AW'(i)) begin
                    weight_q[i] <= cfg_wdata[W_BITS-1:0];
                end
            end
            if (cfg_addr == CFG_AW'(N_INPUTS + CFG_THRESH_OFS)) begin
                thresh_q <= cfg_wdata[U_BITS-1:0];
            end
            if (cfg_addr == CFG_AW'(N_INPUTS + CFG_SHIFT_OFS)) begin
                shift_q <= cfg_wdata[SHIFT_BITS-1:0];
            end
            if (cfg_addr == CFG_AW'(N_INPUTS + CFG_REFRAC_OFS)) begin
                refrac_len_q <= cfg_wdata[REFRAC_BITS-1:0];
            end
            if (cfg_addr == CFG_AW'(N_INPUTS + CFG_MODE_OFS)) begin
                mode_q <= cfg_wdata[0];
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state and handshake output.
    always_comb begin
        state_d    = state_q;
        step_ready = 1'b0;
        unique case (state_q)
            IDLE: begin
                step_ready = 1'b1;
                if (step) begin
                    state_d = SUM;
                end
            end
            SUM:     state_d = UPDATE;
            UPDATE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Membrane update: leak, integrate with saturation, then fire/refractory decision.
    always_comb begin
        leak_u   = u_q - (u_q >>> shift_q);
        u_int    = U_BITS'(saturate(32'(leak_u) + 32'(sum_q), U_BITS));
        u_sub    = U_BITS'(saturate(32'(u_int) - 32'(thresh_q), U_BITS));
        u_d      = u_int;
        refrac_d = refrac_cnt_q;
        spike_d  = 1'b0;
        if (refrac_cnt_q != '0) begin
            u_d      = leak_u;
            refrac_d = refrac_cnt_q - REFRAC_BITS'(1);
        end else if (u_int >= thresh_q) begin
            spike_d  = 1'b1;
            refrac_d = refrac_len_q;
            u_d      = mode_q ? '0 : u_sub;
        end
    end

    // Datapath registers: capture inputs on accept, sum in SUM, commit in UPDATE.
    always_ff @(posedge clk) begin
        if (reset) begin
            x_q           <= '0;
            sum_q         <= '0;
            u_q           <= '0;
            refrac_cnt_q  <= '0;
            spike_q       <= 1'b0;
            spike_valid_q <= 1'b0;
        end else begin
            spike_valid_q <= 1'b0;
            if (step && step_ready) begin
                x_q <= x;
            end
            if (state_q == SUM) begin
                sum_q <= sum_comb;
            end
            if (state_q == UPDATE) begin
                u_q           <= u_d;
                refrac_cnt_q  <= refrac_d;
                spike_q       <= spike_d;
                spike_valid_q <= 1'b1;
            end
        end
    end

    assign spike       = spike_q;
    assign spike_valid = spike_valid_q;
    assign u_out       = u_q;
    assign refractory  = (refrac_cnt_q != '0);

endmodule
